ex_stage_control: RTL and testbench
===================================

// Module: ex_stage_control
// PURPOSE
//   Control sequencer for the EX-stage ALU datapath in the 5-stage pipeline.
//   - Latches decoded ID control into the ID/EX control register: ALU op, shift-select, immediate-select.
//   - Tracks destination/writeback info through the EX, MEM and WB slots.
//   - Computes registered forwarding selects for the ALU operand muxes.
//   - Detects load-use hazards and inserts bubbles; handles ID-requested flushes.
// PARAMETERS
//   REG_ADDR_W  5   register-file address width
//   ALUOP_W     4   ALU operation code width
//   STALL_CNT_W 16  width of saturating stall-cycle counter
// PORTS
//   clk         in   1           pipeline clock; all state updates on rising edge
//   rst         in   1           synchronous, active-high reset
//   idValid     in   1           ID holds a valid instruction
//   idAluOp     in   ALUOP_W     decoded ALU operation
//   idShift     in   1           ALU A takes shift amount (else rs/PC+4)
//   idAluImm    in   1           ALU B takes immediate (else rt/zero)
//   idRs        in   REG_ADDR_W  source register A
//   idRt        in   REG_ADDR_W  source register B
//   idUsesRs    in   1           instruction reads rs
//   idUsesRt    in   1           instruction reads rt
//   idRegWrite  in   1           instruction writes a register
//   idWriteReg  in   REG_ADDR_W  destination register
//   idMemToReg  in   1           instruction is a load
//   idFlush     in   1           kill the ID instruction (taken branch/jump)
//   ealuc       out  ALUOP_W     EX ALU operation
//   eshift      out  1           EX shift-select
//   ealuimm     out  1           EX immediate-select
//   eValid      out  1           EX slot holds a real instruction (0 = bubble)
//   eRegWrite   out  1           EX writes a register (forced 0 on bubble)
//   eMemToReg   out  1           EX is a load
//   eWriteReg   out  REG_ADDR_W  EX destination register
//   forwardA    out  2           ALU A source: 0 regfile, 1 EX/MEM result, 2 MEM/WB result
//   forwardB    out  2           ALU B source, same encoding
//   stallId     out  1           hold PC and IF/ID this cycle (combinational)
//   stallCount  out  STALL_CNT_W number of load-use stall cycles
// BEHAVIOUR
//   Reset: all registered outputs are 0 one cycle after rst=1; EX/MEM/WB shadow slots become bubbles.
//   Shadow slots (internal): mSlot={regWrite,writeReg,memToReg}, wSlot likewise.
//     Each cycle wSlot<=mSlot and mSlot<=EX slot; they always advance, never stall.
//   Load-use hazard (combinational):
//     hz = idValid & eMemToReg & eRegWrite & eWriteReg!=0 &
//          ((idUsesRs & idRs==eWriteReg) | (idUsesRt & idRt==eWriteReg)).
//     stallId = hz & ~idFlush.
//   EX register update priority: rst > idFlush > hz > normal.
//     idFlush or hz, or ~idValid: load a bubble (all control 0, forward=0, eValid=0).
//     Normal: load all id* fields, set eValid=1, load the computed forward selects.
//   Forward select for operand X (rs for A, rt for B), computed in ID, registered into EX:
//     2'd1 if eRegWrite & eWriteReg!=0 & eWriteReg==X & ~eMemToReg;
//     else 2'd2 if mSlot.regWrite & mSlot.writeReg!=0 & mSlot.writeReg==X;
//     else 2'd0.
//     Nearer producer wins when EX and MEM both match.
//     The EX-load case never forwards; it is covered by the stall path.
//     Unused operand (idUsesX=0): 2'd0. Register 0: always 2'd0.
//   Latency:
//     - control reaches EX outputs 1 cycle after ID presentation;
//     - a load-use stall is exactly 1 bubble cycle; after it, the dependent gets forwardX=2.
//   stallCount: increments on each cycle with stallId=1; saturates at all-ones; cleared by rst.
//   rst asserted mid-stall: stallId may be high that cycle; next cycle all state is cleared.
//   Simultaneous idFlush & hz: flush wins, stallId=0, no count increment.
// STRUCTURE
//   Shared package: FWD_REGFILE=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2; ALU op encodings; REG_ZERO.
//   One sub-module: ex_forward_select. Combinational; inputs X and usesX plus EX/MEM slot info;
//     output 2-bit select. Instantiated twice (A, B).
//   Hazard logic, EX control register and shadow slots live in the top module.
// TESTING
//   1. rst=1 for 2 cycles -> every output 0, stallCount=0, eValid=0.
//   2. add r3<-r1,r2 then sub r4<-r3,r5 -> sub in EX: forwardA=1, forwardB=0, no stall.
//   3. add r3, nop, or r6<-r3,r3 -> or in EX: forwardA=2, forwardB=2.
//   4. lw r7 then add r8<-r7,r1 -> stallId=1 for 1 cycle, eValid=0 bubble,
//      add then in EX with forwardA=2; stallCount=1.
//   5. lw r7 then dependent add with idFlush=1 -> stallId=0, bubble, stallCount unchanged.
//   6. write to r0 followed by a reader of r0 -> forwardA=0; load to r0 with a
//      dependent reader -> no stall.

Source files
------------

// File: rtl/ex_stage_control_pkg.sv
// Shared definitions for the EX-stage control slice.
// Forward-select encodings, ALU operation codes and the hard-wired zero register.
// Imported by ex_forward_select and ex_stage_control.
package ex_stage_control_pkg;

    // ALU operand source selects, shared by both operand muxes.
    localparam logic [1:0] FWD_REGFILE = 2'd0;  // value read from the register file
    localparam logic [1:0] FWD_EXMEM   = 2'd1;  // EX/MEM pipeline register (previous ALU result)
    localparam logic [1:0] FWD_MEMWB   = 2'd2;  // MEM/WB pipeline register (ALU or load result)

    // Register 0 is hard-wired to zero; writes to it are discarded, so it is never a producer.
    localparam int REG_ZERO = 0;

    // ALU operation codes as produced by the decoder.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_LUI = 4'd8
    } aluOp_e;

endpackage

// File: rtl/ex_forward_select.sv
// Purpose: pick the ALU operand source for one source register, evaluated in ID.
// Latency: combinational; the caller registers the result into the EX slot.
// Backpressure: none; a load in EX is never forwarded, the stall path covers it.
// Ports:
//   srcReg, usesSrc             source register under test and whether it is read
//   eRegWrite/eWriteReg/eMemToReg  producer currently in EX (lands in EX/MEM next cycle)
//   mRegWrite/mWriteReg         producer currently in MEM (lands in MEM/WB next cycle)
//   fwdSel                      FWD_REGFILE / FWD_EXMEM / FWD_MEMWB
module ex_forward_select
    import ex_stage_control_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] srcReg,
    input  logic                  usesSrc,
    input  logic                  eRegWrite,
    input  logic [REG_ADDR_W-1:0] eWriteReg,
    input  logic                  eMemToReg,
    input  logic                  mRegWrite,
    input  logic [REG_ADDR_W-1:0] mWriteReg,
    output logic [1:0]            fwdSel
);

    always_comb begin
        fwdSel = FWD_REGFILE;
        // Checking srcReg against zero also excludes a zero destination on either producer.
        if (usesSrc && (srcReg != REG_ADDR_W'(REG_ZERO))) begin
            // Nearer producer first. A load in EX falls through to the MEM check:
            // its data is not ready yet and the hazard logic bubbles the consumer.
            if (eRegWrite && !eMemToReg && (eWriteReg == srcReg)) begin
                fwdSel = FWD_EXMEM;
            end else if (mRegWrite && (mWriteReg == srcReg)) begin
                fwdSel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/ex_stage_control.sv
// Purpose: ID/EX control register, EX/MEM destination tracking, forwarding selects, load-use interlock.
// Latency: ID control appears on EX outputs 1 cycle later; a load-use stall costs exactly one bubble.
// Backpressure: stallId (combinational) holds PC and IF/ID; downstream slots always advance.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id*                          decoded instruction in ID, plus idFlush to kill it
//   ealuc/eshift/ealuimm         EX ALU controls
//   eValid/eRegWrite/eMemToReg/eWriteReg  EX slot status (all zero on a bubble)
//   forwardA/forwardB            registered ALU operand selects
//   stallId, stallCount          load-use interlock and saturating stall-cycle counter
module ex_stage_control
    import ex_stage_control_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int ALUOP_W     = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   idValid,
    input  logic [ALUOP_W-1:0]     idAluOp,
    input  logic                   idShift,
    input  logic                   idAluImm,
    input  logic [REG_ADDR_W-1:0]  idRs,
    input  logic [REG_ADDR_W-1:0]  idRt,
    input  logic                   idUsesRs,
    input  logic                   idUsesRt,
    input  logic                   idRegWrite,
    input  logic [REG_ADDR_W-1:0]  idWriteReg,
    input  logic                   idMemToReg,
    input  logic                   idFlush,
    output logic [ALUOP_W-1:0]     ealuc,
    output logic                   eshift,
    output logic                   ealuimm,
    output logic                   eValid,
    output logic                   eRegWrite,
    output logic                   eMemToReg,
    output logic [REG_ADDR_W-1:0]  eWriteReg,
    output logic [1:0]             forwardA,
    output logic [1:0]             forwardB,
    output logic                   stallId,
    output logic [STALL_CNT_W-1:0] stallCount
);

    // MEM shadow slot. Only the destination matters once an instruction leaves EX:
    // a load's data is available by MEM/WB, so its load flag is not carried along.
    // Nothing here consumes the WB slot: the register file's write-through already
    // serves readers of a producer that is in WB while they sit in ID, so no WB
    // state is kept.
    typedef struct packed {
        logic                  regWrite;
        logic [REG_ADDR_W-1:0] writeReg;
    } slot_t;

    slot_t      mSlot;
    logic [1:0] fwdSelA;
    logic [1:0] fwdSelB;
    logic       hz;
    logic       loadBubble;

    ex_forward_select #(.REG_ADDR_W(REG_ADDR_W)) uFwdA (
        .srcReg    (idRs),
        .usesSrc   (idUsesRs),
        .eRegWrite (eRegWrite),
        .eWriteReg (eWriteReg),
        .eMemToReg (eMemToReg),
        .mRegWrite (mSlot.regWrite),
        .mWriteReg (mSlot.writeReg),
        .fwdSel    (fwdSelA)
    );

    ex_forward_select #(.REG_ADDR_W(REG_ADDR_W)) uFwdB (
        .srcReg    (idRt),
        .usesSrc   (idUsesRt),
        .eRegWrite (eRegWrite),
        .eWriteReg (eWriteReg),
        .eMemToReg (eMemToReg),
        .mRegWrite (mSlot.regWrite),
        .mWriteReg (mSlot.writeReg),
        .fwdSel    (fwdSelB)
    );

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        hz = idValid && eMemToReg && eRegWrite
             && (eWriteReg != REG_ADDR_W'(REG_ZERO))
             && ((idUsesRs && (idRs == eWriteReg)) || (idUsesRt && (idRt == eWriteReg)));
        // A flushed instruction is discarded anyway, so holding it would only waste a cycle.
        stallId    = hz && !idFlush;
        loadBubble = idFlush || hz || !idValid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ealuc      <= '0;
            eshift     <= 1'b0;
            ealuimm    <= 1'b0;
            eValid     <= 1'b0;
            eRegWrite  <= 1'b0;
            eMemToReg  <= 1'b0;
            eWriteReg  <= '0;
            forwardA   <= FWD_REGFILE;
            forwardB   <= FWD_REGFILE;
            mSlot      <= '0;
            stallCount <= '0;
        end else begin
            // Shadow slot advances unconditionally; a bubble in EX becomes a bubble in MEM.
            mSlot.regWrite <= eRegWrite;
            mSlot.writeReg <= eWriteReg;

            if (loadBubble) begin
                ealuc     <= '0;
                eshift    <= 1'b0;
                ealuimm   <= 1'b0;
                eValid    <= 1'b0;
                eRegWrite <= 1'b0;
                eMemToReg <= 1'b0;
                eWriteReg <= '0;
                forwardA  <= FWD_REGFILE;
                forwardB  <= FWD_REGFILE;
            end else begin
                ealuc     <= idAluOp;
                eshift    <= idShift;
                ealuimm   <= idAluImm;
                eValid    <= 1'b1;
                eRegWrite <= idRegWrite;
                eMemToReg <= idMemToReg;
                eWriteReg <= idWriteReg;
                forwardA  <= fwdSelA;
                forwardB  <= fwdSelB;
            end

            if (stallId && (stallCount != {STALL_CNT_W{1'b1}})) begin
                stallCount <= stallCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_control.sv
// Directed bench for ex_stage_control: reset, EX/MEM forwarding, load-use
// interlock, flush priority, register 0 and a narrow saturating stall counter.
module tb_ex_stage_control;
    import ex_stage_control_pkg::*;

    localparam int RW = 5;
    localparam int OW = 4;
    localparam int CW = 2;   // narrow counter so saturation is reachable

    logic          clk = 1'b0;
    logic          rst;
    logic          idValid, idShift, idAluImm, idUsesRs, idUsesRt;
    logic          idRegWrite, idMemToReg, idFlush;
    logic [OW-1:0] idAluOp;
    logic [RW-1:0] idRs, idRt, idWriteReg;
    logic [OW-1:0] ealuc;
    logic          eshift, ealuimm, eValid, eRegWrite, eMemToReg, stallId;
    logic [RW-1:0] eWriteReg;
    logic [1:0]    forwardA, forwardB;
    logic [CW-1:0] stallCount;

    int total = 0;
    int bad   = 0;

    ex_stage_control #(.REG_ADDR_W(RW), .ALUOP_W(OW), .STALL_CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .idValid    (idValid),
        .idAluOp    (idAluOp),
        .idShift    (idShift),
        .idAluImm   (idAluImm),
        .idRs       (idRs),
        .idRt       (idRt),
        .idUsesRs   (idUsesRs),
        .idUsesRt   (idUsesRt),
        .idRegWrite (idRegWrite),
        .idWriteReg (idWriteReg),
        .idMemToReg (idMemToReg),
        .idFlush    (idFlush),
        .ealuc      (ealuc),
        .eshift     (eshift),
        .ealuimm    (ealuimm),
        .eValid     (eValid),
        .eRegWrite  (eRegWrite),
        .eMemToReg  (eMemToReg),
        .eWriteReg  (eWriteReg),
        .forwardA   (forwardA),
        .forwardB   (forwardB),
        .stallId    (stallId),
        .stallCount (stallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one decoded instruction into ID.
    task automatic setId(input logic v, input logic [OW-1:0] op, input logic sh, input logic im,
                         input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                         input logic ur, input logic ut, input logic rw,
                         input logic [RW-1:0] wr, input logic ml, input logic fl);
        idValid = v;  idAluOp = op;  idShift = sh;  idAluImm = im;
        idRs = rs;    idRt = rt;     idUsesRs = ur; idUsesRt = ut;
        idRegWrite = rw; idWriteReg = wr; idMemToReg = ml; idFlush = fl;
    endtask

    task automatic idle();
        setId(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lw r7 followed by add r8<-r7,r1; walks through the stall and the release.
    task automatic loadUse(input string tag, input logic [CW-1:0] cntAfter);
        setId(1'b1, ALU_ADD, 1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        setId(1'b1, ALU_ADD, 1'b0, 1'b0, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        #1;
        chk({tag, "_stall"}, stallId, 1'b1);
        tick();
        chk({tag, "_bubble"}, eValid, 1'b0);
        chk({tag, "_cnt"}, stallCount, cntAfter);
        chk({tag, "_nostall2"}, stallId, 1'b0);
        tick();
        chk({tag, "_fwdA"}, forwardA, FWD_MEMWB);
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // 1. reset
        tick();
        tick();
        chk("rst_ealuc", ealuc, '0);
        chk("rst_eshift", eshift, 1'b0);
        chk("rst_ealuimm", ealuimm, 1'b0);
        chk("rst_eValid", eValid, 1'b0);
        chk("rst_eRegWrite", eRegWrite, 1'b0);
        chk("rst_eMemToReg", eMemToReg, 1'b0);
        chk("rst_eWriteReg", eWriteReg, '0);
        chk("rst_fwdA", forwardA, 2'd0);
        chk("rst_fwdB", forwardB, 2'd0);
        chk("rst_stallId", stallId, 1'b0);
        chk("rst_cnt", stallCount, '0);
        rst = 1'b0;
        tick();

        // 2. add r3<-r1,r2 ; sub r4<-r3,r5
        setId(1'b1, ALU_ADD, 1'b0, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        chk("add_ealuc", ealuc, ALU_ADD);
        chk("add_eValid", eValid, 1'b1);
        chk("add_eWriteReg", eWriteReg, 5'd3);
        chk("add_fwdA", forwardA, 2'd0);
        setId(1'b1, ALU_SUB, 1'b0, 1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
        #1;
        chk("sub_nostall", stallId, 1'b0);
        tick();
        chk("sub_ealuc", ealuc, ALU_SUB);
        chk("sub_fwdA", forwardA, FWD_EXMEM);
        chk("sub_fwdB", forwardB, FWD_REGFILE);
        chk("sub_eWriteReg", eWriteReg, 5'd4);

        // 3. add r3 ; nop ; or r6<-r3,r3 (shift/imm flags carried through)
        setId(1'b1, ALU_ADD, 1'b0, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        chk("nop_eValid", eValid, 1'b0);
        chk("nop_eRegWrite", eRegWrite, 1'b0);
        setId(1'b1, ALU_OR, 1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
        tick();
        chk("or_fwdA", forwardA, FWD_MEMWB);
        chk("or_fwdB", forwardB, FWD_MEMWB);
        chk("or_eshift", eshift, 1'b1);
        chk("or_ealuimm", ealuimm, 1'b1);

        // nearer producer wins: add r3 ; add r3 ; reader of r3 (rt unused)
        setId(1'b1, ALU_ADD, 1'b0, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        setId(1'b1, ALU_ADD, 1'b0, 1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        setId(1'b1, ALU_SLL, 1'b1, 1'b0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0);
        tick();
        chk("near_fwdA", forwardA, FWD_EXMEM);
        chk("unused_fwdB", forwardB, FWD_REGFILE);

        // 4. load-use stall
        loadUse("lu1", 2'd1);
        chk("lu1_ealuc", ealuc, ALU_ADD);
        chk("lu1_eValid", eValid, 1'b1);
        chk("lu1_fwdB", forwardB, FWD_REGFILE);

        // 5. load-use with flush: flush wins, no stall, no count
        setId(1'b1, ALU_ADD, 1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        setId(1'b1, ALU_ADD, 1'b0, 1'b0, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1);
        #1;
        chk("flush_nostall", stallId, 1'b0);
        tick();
        chk("flush_bubble", eValid, 1'b0);
        chk("flush_eRegWrite", eRegWrite, 1'b0);
        chk("flush_cnt", stallCount, 2'd1);

        // 6. register 0: ALU write then reader, load then reader
        setId(1'b1, ALU_ADD, 1'b0, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        setId(1'b1, ALU_ADD, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        tick();
        chk("r0_fwdA", forwardA, FWD_REGFILE);
        chk("r0_fwdB", forwardB, FWD_REGFILE);
        setId(1'b1, ALU_ADD, 1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        setId(1'b1, ALU_ADD, 1'b0, 1'b0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        #1;
        chk("r0load_nostall", stallId, 1'b0);
        tick();
        chk("r0load_eValid", eValid, 1'b1);
        chk("r0load_fwdA", forwardA, FWD_REGFILE);

        // saturation of the 2-bit counter: 1 -> 2 -> 3 -> 3
        loadUse("lu2", 2'd2);
        loadUse("lu3", 2'd3);
        loadUse("lu4", 2'd3);

        // reset asserted mid-stall clears everything on the next edge
        setId(1'b1, ALU_ADD, 1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        setId(1'b1, ALU_ADD, 1'b0, 1'b0, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rststall_stallId", stallId, 1'b1);
        tick();
        chk("rststall_cnt", stallCount, '0);
        chk("rststall_eMemToReg", eMemToReg, 1'b0);
        chk("rststall_eWriteReg", eWriteReg, '0);
        chk("rststall_stallId2", stallId, 1'b0);
        rst = 1'b0;
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
